// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit timing helper and default
// parameters common to the transmitter and receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_RECV  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    localparam int DEFAULT_BIT_RATE     = 9600;
    localparam int DEFAULT_CLK_HZ       = 50_000_000;
    localparam int DEFAULT_PAYLOAD_BITS = 8;
    localparam int DEFAULT_STOP_BITS    = 1;

    // Clock cycles per line bit, computed from the bit and clock periods in ns
    // so both sides of the link round identically.
    function automatic int cycles_per_bit(input int bit_rate, input int clk_hz);
        return (1_000_000_000 / bit_rate) / (1_000_000_000 / clk_hz);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous input; reset value selectable so
// idle-high and idle-low pins both come out of reset in their idle state.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the asynchronous input.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit qualify at mid-bit, LSB-first data capture,
// stop-bit check, one-cycle valid pulse with frame error / break flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BIT_RATE     = DEFAULT_BIT_RATE,
    parameter int CLK_HZ       = DEFAULT_CLK_HZ,
    parameter int PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS,
    parameter int STOP_BITS    = DEFAULT_STOP_BITS
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_frame_err,
    output logic                    uart_rx_break
);

    localparam int CPB  = cycles_per_bit(BIT_RATE, CLK_HZ);
    localparam int HALF = CPB / 2;
    localparam int CW   = 1 + $clog2(CPB);

    logic                    rxd_s;
    uart_state_t             state, next_state;
    logic [CW-1:0]           cycle_counter;
    logic [3:0]              bit_counter;
    logic [PAYLOAD_BITS-1:0] shift_reg;
    logic [PAYLOAD_BITS:0]   shifted;
    logic                    err;
    logic                    sample;      // line is sampled this cycle
    logic                    frame_done;  // final stop bit sampled this cycle

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (uart_rxd),
        .q      (rxd_s)
    );

    // New bit enters at the MSB so the first (LSB) bit ends up in bit 0.
    assign shifted = {rxd_s, shift_reg};

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= UART_IDLE;
        else         state <= next_state;
    end

    // Next-state decode and sample strobes.
    always_comb begin
        next_state = state;
        sample     = 1'b0;
        frame_done = 1'b0;
        case (state)
            UART_IDLE: begin
                if (uart_rx_en && !rxd_s) next_state = UART_START;
            end
            UART_START: begin
                if (cycle_counter == CW'(HALF)) begin
                    sample     = 1'b1;
                    next_state = rxd_s ? UART_IDLE : UART_RECV;
                end
            end
            UART_RECV: begin
                if (cycle_counter == CW'(CPB - 1)) begin
                    sample = 1'b1;
                    if (bit_counter == 4'(PAYLOAD_BITS - 1)) next_state = UART_STOP;
                end
            end
            UART_STOP: begin
                if (cycle_counter == CW'(CPB - 1)) begin
                    sample = 1'b1;
                    if (bit_counter == 4'(STOP_BITS - 1)) begin
                        next_state = UART_IDLE;
                        frame_done = 1'b1;
                    end
                end
            end
            default: next_state = UART_IDLE;
        endcase
    end

    // Bit timing: both counters restart on state entry; cycle counter also
    // restarts on each sample so samples land one bit period apart.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cycle_counter <= '0;
            bit_counter   <= '0;
        end else if (next_state != state) begin
            cycle_counter <= '0;
            bit_counter   <= '0;
        end else if (sample) begin
            cycle_counter <= '0;
            bit_counter   <= bit_counter + 4'd1;
        end else if (state != UART_IDLE) begin
            cycle_counter <= cycle_counter + CW'(1);
        end
    end

    // Payload capture and sticky stop-bit error for the current frame.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            shift_reg <= '0;
            err       <= 1'b0;
        end else if (state == UART_IDLE) begin
            err <= 1'b0;
        end else if (sample && state == UART_RECV) begin
            shift_reg <= shifted[PAYLOAD_BITS:1];
        end else if (sample && state == UART_STOP && !rxd_s) begin
            err <= 1'b1;
        end
    end

    // Present the frame the cycle after the last stop sample; flags hold
    // with the data until the next frame.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            uart_rx_valid     <= 1'b0;
            uart_rx_data      <= '0;
            uart_rx_frame_err <= 1'b0;
            uart_rx_break     <= 1'b0;
        end else begin
            uart_rx_valid <= frame_done;
            if (frame_done) begin
                uart_rx_data      <= shift_reg;
                uart_rx_frame_err <= err || !rxd_s;
                uart_rx_break     <= (err || !rxd_s) && (shift_reg == '0);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: per-cycle line waveforms are built, played into the DUT,
// and the observed valid events are compared against constants and against a
// frame-timing reference model evaluated over the same waveform.
module tb_uart_rx;

    localparam int CLK_HZ   = 50_000_000;
    localparam int BIT_RATE = 5_000_000;
    localparam int CPB      = CLK_HZ / BIT_RATE;  // 10
    localparam int HALF     = CPB / 2;            // 5
    localparam int MAXLEN   = 4000;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       ferr;
        logic       brk;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        bit         stop_low;
        int         exp_cyc;
        logic [7:0] exp_data;
        bit         exp_ferr;
        bit         exp_brk;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       rxd2 = 1'b1;
    logic       uart_rx_en = 1'b1;
    logic       uart_rx_valid, valid2;
    logic [7:0] uart_rx_data, data2;
    logic       uart_rx_frame_err, ferr2;
    logic       uart_rx_break, brk2;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int seg_base = 0;
    int seg_len = 0;
    bit cur_en = 1'b1;
    bit line_w[MAXLEN];
    bit line2_w[MAXLEN];
    bit en_w[MAXLEN];
    bit rst_w[MAXLEN];
    ev_t obs_q[$], obs2_q[$], exp_q[$];
    vec_t tbl[6];

    uart_rx #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ), .PAYLOAD_BITS(8), .STOP_BITS(1)) dut (
        .clk(clk), .resetn(resetn), .uart_rxd(uart_rxd), .uart_rx_en(uart_rx_en),
        .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
        .uart_rx_frame_err(uart_rx_frame_err), .uart_rx_break(uart_rx_break)
    );

    uart_rx #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ), .PAYLOAD_BITS(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .resetn(resetn), .uart_rxd(rxd2), .uart_rx_en(uart_rx_en),
        .uart_rx_valid(valid2), .uart_rx_data(data2),
        .uart_rx_frame_err(ferr2), .uart_rx_break(brk2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid pulse with its segment-relative cycle.
    always @(negedge clk) begin
        if (uart_rx_valid)
            obs_q.push_back('{cyc - seg_base, uart_rx_data, uart_rx_frame_err, uart_rx_break});
        if (valid2)
            obs2_q.push_back('{cyc - seg_base, data2, ferr2, brk2});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_seg();
        seg_len = 0;
    endtask

    task automatic push_cycle(input bit l, input bit l2);
        if (seg_len < MAXLEN) begin
            line_w[seg_len]  = l;
            line2_w[seg_len] = l2;
            en_w[seg_len]    = cur_en;
            rst_w[seg_len]   = 1'b1;
            seg_len++;
        end
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) push_cycle(1'b1, 1'b1);
    endtask

    task automatic add_low(input int n);
        for (int i = 0; i < n; i++) push_cycle(1'b0, 1'b1);
    endtask

    // Append a frame: start bit, 8 data bits LSB first, stop bit(s).
    task automatic add_frame(input logic [7:0] d, input bit stop_low, input int stops = 1,
                             input bit to2 = 1'b0);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        for (int s = 0; s < stops; s++) bits.push_back(!stop_low);
        foreach (bits[b])
            for (int c = 0; c < CPB; c++)
                push_cycle(to2 ? 1'b1 : bits[b], to2 ? bits[b] : 1'b1);
    endtask

    // Drive the segment one cycle at a time.
    task automatic play();
        obs_q.delete();
        obs2_q.delete();
        seg_base = cyc;
        for (int k = 0; k < seg_len; k++) begin
            uart_rxd   = line_w[k];
            rxd2       = line2_w[k];
            uart_rx_en = en_w[k];
            resetn     = rst_w[k];
            @(posedge clk);
            #1;
        end
    endtask

    // Line level as seen after the two-cycle synchronizer delay is taken
    // into account by the caller; outside the segment the line idles high.
    function automatic bit ln(input int k);
        if (k < 0 || k >= seg_len) return 1'b1;
        return line_w[k];
    endfunction

    // Reference model from the frame timing rules: a receiver idle at cycle d
    // that is enabled and sees the line low (two cycles late) enters START at
    // d+1, samples the start bit HALF later, then each further bit one CPB
    // apart; valid follows the final stop sample by one cycle.
    task automatic run_model();
        int d;
        exp_q.delete();
        d = 0;
        while (d < seg_len) begin
            if (en_w[d] && !ln(d - 2)) begin
                int ss;
                ss = d + 1 + HALF;
                if (ln(ss - 2)) begin
                    d = ss + 1;
                end else begin
                    logic [7:0] v;
                    bit e;
                    int vc;
                    v = '0;
                    for (int i = 0; i < 8; i++) v[i] = ln(ss + (i + 1) * CPB - 2);
                    e = !ln(ss + 9 * CPB - 2);
                    vc = ss + 9 * CPB + 1;
                    exp_q.push_back('{vc, v, e, e && (v == 8'h00)});
                    d = vc;
                end
            end else begin
                d++;
            end
        end
    endtask

    task automatic check_model(input string name);
        int n;
        run_model();
        chk($sformatf("%s count", name), obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d] cycle", name, i), obs_q[i].cyc,  exp_q[i].cyc);
            chk($sformatf("%s[%0d] data",  name, i), obs_q[i].data, exp_q[i].data);
            chk($sformatf("%s[%0d] ferr",  name, i), obs_q[i].ferr, exp_q[i].ferr);
            chk($sformatf("%s[%0d] brk",   name, i), obs_q[i].brk,  exp_q[i].brk);
        end
    endtask

    task automatic chk_ev(input string name, input int idx, input int c, input logic [7:0] d,
                          input bit f, input bit b);
        if (obs_q.size() > idx) begin
            chk($sformatf("%s cycle", name), obs_q[idx].cyc,  c);
            chk($sformatf("%s data",  name), obs_q[idx].data, d);
            chk($sformatf("%s ferr",  name), obs_q[idx].ferr, f);
            chk($sformatf("%s brk",   name), obs_q[idx].brk,  b);
        end else begin
            chk($sformatf("%s present", name), 0, 1);
        end
    endtask

    initial begin
        tbl[0] = '{8'hA5, 1'b0, 99, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b1, 99, 8'h3C, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 1'b1, 99, 8'h00, 1'b1, 1'b1};
        tbl[3] = '{8'hFF, 1'b0, 99, 8'hFF, 1'b0, 1'b0};
        tbl[4] = '{8'h01, 1'b1, 99, 8'h01, 1'b1, 1'b0};
        tbl[5] = '{8'h80, 1'b0, 99, 8'h80, 1'b0, 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset valid", uart_rx_valid, 0);
        chk("reset data",  uart_rx_data, 0);
        chk("reset ferr",  uart_rx_frame_err, 0);
        chk("reset brk",   uart_rx_break, 0);
        resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Single frames from idle.
        foreach (tbl[t]) begin
            clear_seg();
            add_frame(tbl[t].data, tbl[t].stop_low);
            add_idle(150);
            play();
            chk($sformatf("tbl%0d count", t), obs_q.size(), 1);
            chk_ev($sformatf("tbl%0d", t), 0, tbl[t].exp_cyc, tbl[t].exp_data,
                   tbl[t].exp_ferr, tbl[t].exp_brk);
            chk($sformatf("tbl%0d held data", t), uart_rx_data, tbl[t].exp_data);
            chk($sformatf("tbl%0d held ferr", t), uart_rx_frame_err, tbl[t].exp_ferr);
        end

        // Back-to-back frames, no idle gap.
        clear_seg();
        add_frame(8'h00, 1'b0);
        add_frame(8'hFF, 1'b0);
        add_idle(150);
        play();
        chk_ev("b2b first", 0, 99, 8'h00, 1'b0, 1'b0);
        chk_ev("b2b second", 1, 199, 8'hFF, 1'b0, 1'b0);
        check_model("b2b");

        // 3-cycle glitch, then a real frame whose detection needs IDLE by cycle 9.
        clear_seg();
        add_low(3);
        add_idle(4);
        add_frame(8'hC3, 1'b0);
        add_idle(150);
        play();
        chk("glitch count", obs_q.size(), 1);
        chk_ev("glitch follow", 0, 106, 8'hC3, 1'b0, 1'b0);

        // Line held low for 25 bit-times: repeated break frames.
        clear_seg();
        add_low(25 * CPB);
        add_idle(300);
        play();
        chk_ev("break first", 0, 99, 8'h00, 1'b1, 1'b1);
        chk_ev("break second", 1, 196, 8'h00, 1'b1, 1'b1);
        check_model("break");

        // Reset during data bit 4 of 0x81, after a frame that left flags set.
        clear_seg();
        add_frame(8'h3C, 1'b1);
        add_idle(150);
        begin
            int p;
            p = seg_len;
            add_frame(8'h81, 1'b0);
            for (int k = p + 52; k < seg_len; k++) line_w[k] = 1'b1;
            for (int k = p + 52; k < p + 55; k++) rst_w[k] = 1'b0;
        end
        add_idle(150);
        play();
        chk("rst count", obs_q.size(), 1);
        chk("rst valid", uart_rx_valid, 0);
        chk("rst data", uart_rx_data, 0);
        chk("rst ferr", uart_rx_frame_err, 0);
        chk("rst brk", uart_rx_break, 0);
        clear_seg();
        add_frame(8'h42, 1'b0);
        add_idle(150);
        play();
        chk("post-rst count", obs_q.size(), 1);
        chk_ev("post-rst", 0, 99, 8'h42, 1'b0, 1'b0);

        // Enable low across a whole frame: ignored.
        clear_seg();
        cur_en = 1'b0;
        add_frame(8'hA5, 1'b0);
        add_idle(20);
        cur_en = 1'b1;
        add_idle(150);
        play();
        chk("en-off count", obs_q.size(), 0);
        check_model("en-off");

        // Enable dropped mid-frame: frame completes.
        clear_seg();
        add_frame(8'h5A, 1'b0);
        add_idle(150);
        for (int k = 30; k < seg_len; k++) en_w[k] = 1'b0;
        play();
        chk("en-drop count", obs_q.size(), 1);
        chk_ev("en-drop", 0, 99, 8'h5A, 1'b0, 1'b0);

        // Two stop bits on the second instance.
        clear_seg();
        add_frame(8'h5A, 1'b0, 2, 1'b1);
        add_idle(150);
        play();
        chk("stop2 count", obs2_q.size(), 1);
        if (obs2_q.size() > 0) begin
            chk("stop2 cycle", obs2_q[0].cyc, 109);
            chk("stop2 data", obs2_q[0].data, 8'h5A);
            chk("stop2 ferr", obs2_q[0].ferr, 0);
        end
        chk("stop2 main quiet", obs_q.size(), 0);

        // Randomized frame streams against the reference model.
        for (int r = 0; r < 2; r++) begin
            clear_seg();
            for (int f = 0; f < 20; f++) begin
                int p;
                cur_en = ($urandom_range(0, 5) != 0);
                add_idle($urandom_range(0, 25));
                cur_en = 1'b1;
                p = seg_len;
                add_frame(8'($urandom), $urandom_range(0, 7) == 0);
                if ($urandom_range(0, 3) == 0)
                    for (int k = p + 20; k < seg_len; k++) en_w[k] = 1'b0;
            end
            cur_en = 1'b1;
            add_idle(150);
            play();
            check_model($sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: recovers PAYLOAD_BITS-wide frames (start bit, LSB-first data, STOP_BITS stop bits, no parity) from the UART line and presents each frame as a single-cycle valid pulse. It is the receive-side partner of the team's UART transmitter and shares its BIT_RATE, CLK_HZ, PAYLOAD_BITS and STOP_BITS parameters. It sits between the board RX pin and the fabric logic.

## Interface
- BIT_RATE, 9600: line bit rate, bits/s.
- CLK_HZ, 50_000_000: clk frequency, Hz.
- PAYLOAD_BITS, 8: data bits per frame, 1..8.
- STOP_BITS, 1: stop bits per frame, 1..2.
- clk  in  1  system clock; all logic on posedge.
- resetn  in  1  synchronous, active-low reset.
- uart_rxd  in  1  raw asynchronous RX pin; idles high.
- uart_rx_en  in  1  enables start-bit detection; does not abort a frame already in progress.
- uart_rx_valid  out  1  one-cycle pulse: frame received.
- uart_rx_data  out  PAYLOAD_BITS  last received payload; held until the next valid.
- uart_rx_frame_err  out  1  qualifies valid: a stop bit sampled low.
- uart_rx_break  out  1  qualifies valid: frame_err with all data bits zero.

## Operation
- CYCLES_PER_BIT (CPB) = (1e9/BIT_RATE)/(1e9/CLK_HZ), integer division. HALF = CPB/2.
- uart_rxd passes through a 2-flop synchronizer (rxd_s); synchronizer flops reset to 1.
- FSM states: IDLE, START, RECV, STOP. cycle_counter is cleared on every state entry and on every bit sample.
- IDLE: if uart_rx_en and rxd_s==0, go to START.
- START: at cycle_counter==HALF, sample rxd_s. 1 means a glitch: return to IDLE with no output. 0 means go to RECV.
- RECV: at cycle_counter==CPB-1, sample rxd_s and shift it into the MSB of the shift register (LSB-first order), then bit_counter++. After PAYLOAD_BITS samples, go to STOP.
- STOP: at cycle_counter==CPB-1, sample rxd_s; any 0 sets the err flag. After STOP_BITS samples, go to IDLE.
- On leaving STOP, the next cycle does all of the following:
  - pulses valid;
  - loads uart_rx_data;
  - drives frame_err and break for that frame;
  - holds frame_err and break until the next valid.
- Because the stop bit is sampled mid-bit, the receiver is back in IDLE about half a bit early. Back-to-back frames must be received with no loss.
- Reset values: valid 0, data 0, frame_err 0, break 0, FSM IDLE, counters 0, shift register 0, rxd_s 1.
- Reset asserted mid-frame: the frame is abandoned; no valid is produced.
- uart_rx_en deasserted mid-frame: the frame completes normally. A new start is not detected while en is low.
- Line held low indefinitely: after a break frame, IDLE re-enters START immediately and repeats break frames. Downstream treats this as a continuous break.

## Timing
- Take a falling edge on uart_rxd at cycle 0:
  - rxd_s is low at cycle 2;
  - START is entered at cycle 3;
  - the start sample is at cycle 3+HALF;
  - data bit i is sampled at cycle 3+HALF+(i+1)·CPB;
  - the final stop sample is at cycle 3+HALF+(PAYLOAD_BITS+STOP_BITS)·CPB;
  - valid is high at cycle 4+HALF+(PAYLOAD_BITS+STOP_BITS)·CPB.
- Counters are sized 1+$clog2(CPB) bits. bit_counter is 4 bits and never wraps within a frame.
- valid is never high on two consecutive cycles.

## Structure
- Shared package uart_pkg:
  - the FSM state enum (shared encoding with the transmitter);
  - a cycles_per_bit(BIT_RATE, CLK_HZ) function;
  - default parameter constants.
- One sub-module, uart_sync: a 2-flop synchronizer, parameterized reset value, reused by other asynchronous inputs.

## Test plan
Bench uses CLK_HZ=50_000_000 and BIT_RATE=5_000_000, so CPB=10 and HALF=5. Frame format is 8N1 unless noted.

- 0xA5 sent from idle, en=1 -> valid at cycle 99 after the start edge, data=0xA5, frame_err=0, break=0.
- 0x00 then 0xFF sent back-to-back with no idle gap -> two valid pulses 100 cycles apart, data 0x00 then 0xFF.
- 3-cycle low glitch on an idle line -> no valid; FSM back in IDLE by cycle 9.
- 0x3C with the stop bit driven low -> valid with data=0x3C, frame_err=1, break=0. Line held low for 25 bit-times -> valid with data=0x00, frame_err=1, break=1.
- resetn pulsed low during data bit 4 of 0x81 -> no valid; all outputs 0; the next frame 0x42 is received correctly.
- en=0 during a frame's start bit -> ignored; en dropped mid-frame -> the frame completes with a valid pulse. STOP_BITS=2 build: 0x5A -> valid at cycle 109.
